// File: rtl/ape_output_drainer_pkg.sv
// Shared sizing constants and drain FSM state encoding for the APE output SRAM drainer.
package ape_output_drainer_pkg;

    localparam int OUTPUT_HEIGHT   = 4;
    localparam int OUTPUT_WIDTH    = 4;
    localparam int BIN_LEN         = 8;
    localparam int OUTPUT_SRAM_LEN = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/ape_output_drainer_if.sv
// Valid/ready stream from the drainer to the write-back path.
interface ape_output_drainer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ape_output_drainer_drain_fifo.sv
// Small synchronous FIFO used as the output skid buffer; head is visible combinationally.
module drain_fifo #(
    parameter int  WIDTH = 17,
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;

    // Pointer advance with wrap at DEPTH-1 (depth need not be a power of two)
    always_comb begin
        if (r_wr_ptr == PTR_W'(DEPTH - 1)) begin
            w_wr_ptr_next = '0;
        end else begin
            w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
        end
        if (r_rd_ptr == PTR_W'(DEPTH - 1)) begin
            w_rd_ptr_next = '0;
        end else begin
            w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= w_wr_ptr_next;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ape_output_drainer.sv
// Walks the pooled output map row-major, reads the output SRAM and streams each word
// to write-back through a skid FIFO, then pulses done for the tile scheduler.
module ape_output_drainer
    import ape_output_drainer_pkg::*;
#(
    parameter int  OUT_H      = OUTPUT_HEIGHT,
    parameter int  OUT_W      = OUTPUT_WIDTH,
    parameter int  DATA_W     = BIN_LEN * OUTPUT_SRAM_LEN,
    parameter int  RD_LAT     = 1,
    parameter int  FIFO_DEPTH = 2,
    localparam int RW    = $clog2(OUT_H) + 1,
    localparam int CW    = $clog2(OUT_W) + 1,
    localparam int RA    = $clog2(OUT_H),
    localparam int CA    = $clog2(OUT_W),
    localparam int FCW   = $clog2(FIFO_DEPTH + 1),
    localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 2)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [RW-1:0]     num_rows,
    input  logic [CW-1:0]     num_cols,
    output logic              r_enable,
    output logic [RA-1:0]     SRAM_r_out,
    output logic [CA-1:0]     SRAM_c_out,
    input  logic [DATA_W-1:0] SRAM_out,
    ape_output_drainer_if.master stream,
    output logic              busy,
    output logic              done
);

    drain_state_t r_state;
    drain_state_t w_state_next;

    logic [RW-1:0]     r_rows;
    logic [CW-1:0]     r_cols;
    logic [RA-1:0]     r_row;
    logic [CA-1:0]     r_col;
    logic              r_busy;
    logic              r_done;
    logic [RD_LAT-1:0] r_pipe_valid;
    logic [RD_LAT-1:0] r_pipe_last;

    logic [RW-1:0]     w_rows_clamp;
    logic [CW-1:0]     w_cols_clamp;
    logic              w_accept_start;
    logic              w_zero_dim;
    logic              w_col_wrap;
    logic              w_last_addr;
    logic              w_issue;
    logic [SUM_W-1:0]  w_inflight;
    logic [SUM_W-1:0]  w_occupancy;
    logic [DATA_W:0]   w_fifo_head;
    logic [FCW-1:0]    w_fifo_count;
    logic              w_out_valid;
    logic              w_pop;
    logic              w_push;

    assign w_rows_clamp   = (num_rows > RW'(OUT_H)) ? RW'(OUT_H) : num_rows;
    assign w_cols_clamp   = (num_cols > CW'(OUT_W)) ? CW'(OUT_W) : num_cols;
    assign w_accept_start = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_zero_dim     = (w_rows_clamp == '0) || (w_cols_clamp == '0);

    assign w_col_wrap  = ({1'b0, r_col} == (r_cols - CW'(1)));
    assign w_last_addr = w_col_wrap && ({1'b0, r_row} == (r_rows - RW'(1)));

    assign w_out_valid = (w_fifo_count != '0);
    assign w_pop       = w_out_valid && stream.out_ready;
    assign w_push      = r_pipe_valid[RD_LAT-1];

    // Reads still travelling through the SRAM latency pipe
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + SUM_W'(r_pipe_valid[i]);
        end
    end

    // A pop this cycle frees a slot in time for the new read, which keeps one beat per
    // cycle with a FIFO only RD_LAT+1 deep.
    assign w_occupancy = SUM_W'(w_fifo_count) + w_inflight;
    assign w_issue     = (r_state == ISSUE) &&
                         (w_occupancy < (SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop)));

    // Next-state logic for the drain sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = w_zero_dim ? DONE : ISSUE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            ISSUE: begin
                if (w_issue && w_last_addr) begin
                    w_state_next = FLUSH;
                end else begin
                    w_state_next = ISSUE;
                end
            end
            FLUSH: begin
                if ((w_pop && w_fifo_head[DATA_W]) || (!w_out_valid && (w_inflight == '0))) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = FLUSH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ISSUE) || (w_state_next == FLUSH);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Tile dimensions and row/col read counters; counters hold on the final address
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rows <= '0;
            r_cols <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_accept_start) begin
            r_rows <= w_rows_clamp;
            r_cols <= w_cols_clamp;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_issue && !w_last_addr) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + RA'(1);
            end else begin
                r_col <= r_col + CA'(1);
            end
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

    // Latency pipe tagging each read so its data is captured exactly RD_LAT cycles later
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pipe_valid <= '0;
            r_pipe_last  <= '0;
        end else begin
            r_pipe_valid[0] <= w_issue;
            r_pipe_last[0]  <= w_issue && w_last_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_last[i]  <= r_pipe_last[i-1];
            end
        end
    end

    drain_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_drain_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_pipe_last[RD_LAT-1], SRAM_out}),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign r_enable         = w_issue;
    assign SRAM_r_out       = r_row;
    assign SRAM_c_out       = r_col;
    assign stream.out_valid = w_out_valid;
    assign stream.out_data  = w_out_valid ? w_fifo_head[DATA_W-1:0] : '0;
    assign stream.out_last  = w_out_valid && w_fifo_head[DATA_W];
    assign busy             = r_busy;
    assign done             = r_done;

endmodule
